// File: rtl/fibo_dec_sched_pkg.sv
// Shared Fibonacci (FNS) constants: codeword width, decoded width, per-position weights.
// No logic; constants only.
// No flow control; consumed by the segment decoder and scheduler.
package fibo_dec_sched_pkg;

  // Codeword bits per segment and decoded bits per segment
  localparam int FNS_CW = 9;
  localparam int FNS_DW = 8;

  // Weight width: the largest weight (34) needs 6 bits
  localparam int FNS_WW = 6;

  typedef logic [FNS_WW-1:0] fns_weight_t;

  // Weight of code bit i (position i+1); positions 1 and 2 both carry weight 1
  localparam fns_weight_t FNS_WEIGHT [FNS_CW] = '{
    6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34
  };

  // State encodings shared by the scheduler's FSM type
  typedef logic [1:0] fsm_enc_t;

endpackage

// File: rtl/fibo_dec_sched_dec.sv
// dec_8_1: one 9-bit Fibonacci codeword segment to an 8-bit value, masked by per-bit enables.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module dec_8_1
  import fibo_dec_sched_pkg::*;
(
  input  logic [FNS_CW-1:0] code,
  input  logic [FNS_CW-1:0] en,
  output logic [FNS_DW-1:0] seg_val
);

  // Sum the weights of enabled set bits; the sum wraps at FNS_DW bits silently
  always_comb begin
    seg_val = '0;
    for (int i = 0; i < FNS_CW; i++) begin
      if (code[i] && en[i]) begin
        seg_val = seg_val + FNS_DW'(FNS_WEIGHT[i]);
      end
    end
  end

endmodule

// File: rtl/fibo_dec_sched.sv
// Frame decoder: captures NGRP segments, decodes one per cycle through a single dec_8_1.
// Latency: out_valid rises NGRP+1 cycles after the handshake cycle; one frame per NGRP+2 cycles.
// Backpressure: in_ready only in IDLE; HOLD stalls with stable out_data until out_ready.
module fibo_dec_sched
  import fibo_dec_sched_pkg::*;
#(
  parameter int NGRP = 4,
  parameter int CW   = FNS_CW,
  parameter int DW   = FNS_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NGRP*CW-1:0] in_code,
  input  logic [NGRP*CW-1:0] in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NGRP*DW-1:0] out_data,
  output logic               busy
);

  localparam fsm_enc_t ST_IDLE = 2'd0;
  localparam fsm_enc_t ST_DEC  = 2'd1;
  localparam fsm_enc_t ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DEC  = ST_DEC,
    HOLD = ST_HOLD
  } state_t;

  localparam int             SW       = $clog2(NGRP);
  localparam logic [SW-1:0]  SEG_LAST = SW'(NGRP - 1);

  state_t               state;
  logic [SW-1:0]        seg_idx;
  logic [NGRP*CW-1:0]   code_q;
  logic [NGRP*CW-1:0]   en_q;
  logic [CW-1:0]        seg_code;
  logic [CW-1:0]        seg_en;
  logic [DW-1:0]        seg_val;

  // Select the current segment from the captured frame
  always_comb begin
    seg_code = code_q[int'(seg_idx)*CW +: CW];
    seg_en   = en_q[int'(seg_idx)*CW +: CW];
  end

  dec_8_1 u_dec (
    .code    (seg_code),
    .en      (seg_en),
    .seg_val (seg_val)
  );

  // FSM, capture registers, segment counter and output register with registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seg_idx   <= '0;
      code_q    <= '0;
      en_q      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            code_q   <= in_code;
            en_q     <= in_en;
            seg_idx  <= '0;
            state    <= DEC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        DEC: begin
          out_data[int'(seg_idx)*DW +: DW] <= seg_val;
          // Counter parks on the last segment so it never wraps mid-frame
          if (seg_idx == SEG_LAST) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            seg_idx <= seg_idx + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_dec_sched.sv
// Self-checking bench for fibo_dec_sched: scoreboard of reference frames checked on output handshake.
// Covers reset, directed frames, enable masking, HOLD stall, ignored offers, mid-frame reset, back-to-back.
// Inputs driven 1 time unit after posedge; outputs monitored on negedge.
module tb_fibo_dec_sched;

  localparam int NGRP = 4;
  localparam int CW   = 9;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [NGRP*CW-1:0] in_code;
  logic [NGRP*CW-1:0] in_en;
  logic               out_valid;
  logic               out_ready;
  logic [NGRP*DW-1:0] out_data;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int outs        = 0;

  logic [NGRP*DW-1:0] sb[$];

  fibo_dec_sched #(.NGRP(NGRP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: Fibonacci weights built by recurrence, bit i is position i+1
  function automatic logic [DW-1:0] ref_seg(input logic [CW-1:0] c, input logic [CW-1:0] e);
    int f[CW];
    int sum;
    f[0] = 1;
    f[1] = 1;
    for (int i = 2; i < CW; i++) f[i] = f[i-1] + f[i-2];
    sum = 0;
    for (int i = 0; i < CW; i++) if (c[i] && e[i]) sum += f[i];
    return sum[DW-1:0];
  endfunction

  function automatic logic [NGRP*DW-1:0] ref_frame(input logic [NGRP*CW-1:0] c,
                                                   input logic [NGRP*CW-1:0] e);
    logic [NGRP*DW-1:0] r;
    r = '0;
    for (int k = 0; k < NGRP; k++) r[k*DW +: DW] = ref_seg(c[k*CW +: CW], e[k*CW +: CW]);
    return r;
  endfunction

  function automatic logic [NGRP*CW-1:0] rand_vec();
    logic [NGRP*CW-1:0] v;
    for (int k = 0; k < NGRP; k++) v[k*CW +: CW] = CW'($urandom_range(0, 511));
    return v;
  endfunction

  // Scoreboard: every accepted output frame must match the oldest expected frame
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check_eq("unexpected_out", 64'd1, 64'd0);
      else check_eq("out_data", 64'(out_data), 64'(sb.pop_front()));
      outs++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NGRP*CW-1:0] c, input logic [NGRP*CW-1:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) check_eq("timeout_in_ready", 64'd0, 64'd1);
    in_code  = c;
    in_en    = e;
    in_valid = 1'b1;
    sb.push_back(ref_frame(c, e));
    step();
    in_valid = 1'b0;
  endtask

  // lat0: cycles already elapsed since the handshake cycle
  task automatic wait_out(input int exp_lat, input int lat0);
    int lat;
    lat = lat0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) check_eq("timeout_out_valid", 64'd0, 64'd1);
    else check_eq("latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal finish");
    $fatal(1);
  end

  initial begin
    logic [NGRP*CW-1:0] ones;
    logic [NGRP*CW-1:0] fa;
    logic [NGRP*CW-1:0] fb;
    logic [NGRP*DW-1:0] held;
    int prev;
    int n;

    ones      = '1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    in_en     = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    step();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed frame, all enables
    fa = {9'h000, 9'h003, 9'h001, 9'h000};
    send(fa, ones);
    check_eq("dec_busy", 64'(busy), 64'd1);
    check_eq("dec_in_ready", 64'(in_ready), 64'd0);
    wait_out(NGRP + 1, 1);
    check_eq("frame1_data", 64'(out_data), 64'h0002_0100);
    step();

    // Segment 2 masked off
    send(fa, {9'h1FF, 9'h000, 9'h1FF, 9'h1FF});
    wait_out(NGRP + 1, 1);
    check_eq("frame2_data", 64'(out_data), 64'h0000_0100);
    step();

    // HOLD stall for 10 cycles
    out_ready = 1'b0;
    fa = {9'h1FF, 9'h0A5, 9'h100, 9'h055};
    send(fa, ones);
    wait_out(NGRP + 1, 1);
    held = ref_frame(fa, ones);
    check_eq("hold_data", 64'(out_data), 64'(held));
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_stable", 64'(out_data), 64'(held));
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check_eq("release_valid", 64'(out_valid), 64'd0);
    check_eq("release_in_ready", 64'(in_ready), 64'd1);

    // Offer a different frame during DEC; it must be ignored
    fa = {9'h0F0, 9'h00F, 9'h1AA, 9'h155};
    fb = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
    send(fa, ones);
    in_valid = 1'b1;
    in_code  = fb;
    in_en    = ones;
    for (int i = 0; i < 2; i++) begin
      check_eq("dec_ignore_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid = 1'b0;
    wait_out(NGRP + 1, 3);
    check_eq("ignore_data", 64'(out_data), 64'(ref_frame(fa, ones)));
    step();
    check_eq("ignore_idle", 64'(busy), 64'd0);

    // Reset in DEC at seg_idx 2 discards the frame
    send(rand_vec(), ones);
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_out_data", 64'(out_data), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    void'(sb.pop_back());
    step();
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    send(rand_vec(), rand_vec());
    wait_out(NGRP + 1, 1);
    step();

    // Back-to-back frames with out_ready held high
    prev     = -1;
    in_code  = rand_vec();
    in_en    = rand_vec();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        step();
        n++;
      end
      if (!in_ready) check_eq("timeout_b2b", 64'd0, 64'd1);
      if (prev >= 0) check_eq("b2b_period", 64'(cyc - prev), 64'(NGRP + 2));
      prev = cyc;
      sb.push_back(ref_frame(in_code, in_en));
      step();
      in_code = rand_vec();
      in_en   = rand_vec();
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      step();
      n++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    check_eq("out_count", 64'(outs), 64'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
